segway_stim_seq: RTL and testbench

//  Table-driven rider/load-cell stimulus sequencer for the Segway top-level benches.

---
 rtl/segway_stim_seq.sv | 169 ++++++++++++++++
 tb/tb_segway_stim_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/segway_stim_seq.sv
// Table-driven rider-lean / load-cell / BLE-command stimulus sequencer for the Segway benches.
// Build option LEAN_RAMP_EN: slew rider_lean toward each target; when undefined, lean jumps in one cycle.
module segway_stim_seq #(
    parameter int DEPTH    = 16,
    parameter int WAIT_W   = 24,
    parameter int SLEW     = 4,
    parameter int SLEW_DIV = 8,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int ENTRY_W = 2 + 8 + 16 + 12 + 12 + WAIT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [ENTRY_W-1:0]  wr_data,
    input  logic                start,
    input  logic                abort,
    output logic [7:0]          cmd,
    output logic                send_cmd,
    input  logic                cmd_sent,
    output logic signed [15:0]  rider_lean,
    output logic [11:0]         ld_cell_lft,
    output logic [11:0]         ld_cell_rght,
    output logic [ADDR_W-1:0]   step_idx,
    output logic                busy,
    output logic                done
);

    localparam int LDR_LSB  = WAIT_W;
    localparam int LDL_LSB  = WAIT_W + 12;
    localparam int LEAN_LSB = WAIT_W + 24;
    localparam int CMD_LSB  = WAIT_W + 40;
    localparam int HAS_BIT  = WAIT_W + 48;
    localparam int LAST_BIT = WAIT_W + 49;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_TX, RAMP, HOLD, DONE} state_t;

    state_t              state;
    logic [ENTRY_W-1:0]  table_mem [DEPTH];
    logic [ENTRY_W-1:0]  rd_ent;
    logic                cur_last;
    logic [7:0]          cur_cmd;
    logic signed [15:0]  cur_lean;
    logic [WAIT_W-1:0]   cur_wait;
    logic [WAIT_W-1:0]   wait_cnt;

    // One lean tick toward tgt: difference in 17 bits so full-range moves cannot wrap, step clamped to |diff|.
    function automatic logic signed [15:0] slew_step(input logic signed [15:0] cur,
                                                     input logic signed [15:0] tgt);
        logic signed [16:0] diff;
        logic [16:0]        mag;
        logic [15:0]        stp;
        diff = {tgt[15], tgt} - {cur[15], cur};
        mag  = diff[16] ? 17'(-diff) : 17'(diff);
        stp  = (mag > 17'(SLEW)) ? 16'(SLEW) : mag[15:0];
        slew_step = diff[16] ? (cur - stp) : (cur + stp);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en)
            table_mem[wr_addr] <= wr_data;
    end

    assign rd_ent = table_mem[step_idx];
    assign busy   = (state != IDLE);

    // Private copy of the active step so later table writes cannot disturb it.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            cur_last <= rd_ent[LAST_BIT];
            cur_cmd  <= rd_ent[CMD_LSB +: 8];
            cur_lean <= rd_ent[LEAN_LSB +: 16];
            cur_wait <= rd_ent[WAIT_W-1:0];
        end
    end

`ifdef LEAN_RAMP_EN
    localparam int DIV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
    logic [DIV_W-1:0]   div_cnt;
    logic signed [15:0] lean_nxt;
    assign lean_nxt = slew_step(rider_lean, cur_lean);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmd          <= '0;
            send_cmd     <= 1'b0;
            rider_lean   <= '0;
            ld_cell_lft  <= '0;
            ld_cell_rght <= '0;
            step_idx     <= '0;
            done         <= 1'b0;
            wait_cnt     <= '0;
`ifdef LEAN_RAMP_EN
            div_cnt      <= '0;
`endif
        end else if (abort) begin
            state    <= IDLE;
            send_cmd <= 1'b0;
            done     <= 1'b0;
        end else begin
            send_cmd <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        step_idx <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    ld_cell_lft  <= rd_ent[LDL_LSB +: 12];
                    ld_cell_rght <= rd_ent[LDR_LSB +: 12];
`ifdef LEAN_RAMP_EN
                    div_cnt      <= '0;
`endif
                    state        <= rd_ent[HAS_BIT] ? SEND : RAMP;
                end
                SEND: begin
                    send_cmd <= 1'b1;
                    cmd      <= cur_cmd;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (cmd_sent)
                        state <= RAMP;
                end
                RAMP: begin
`ifdef LEAN_RAMP_EN
                    if (rider_lean == cur_lean) begin
                        wait_cnt <= cur_wait;
                        state    <= HOLD;
                    end else if (div_cnt == DIV_W'(SLEW_DIV - 1)) begin
                        div_cnt    <= '0;
                        rider_lean <= lean_nxt;
                        if (lean_nxt == cur_lean) begin
                            wait_cnt <= cur_wait;
                            state    <= HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
`else
                    rider_lean <= cur_lean;
                    wait_cnt   <= cur_wait;
                    state      <= HOLD;
`endif
                end
                HOLD: begin
                    if (wait_cnt == '0) begin
                        if (cur_last || step_idx == ADDR_W'(DEPTH - 1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            step_idx <= step_idx + 1'b1;
                            state    <= LOAD;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_segway_stim_seq.sv
// Self-checking bench for segway_stim_seq: directed scenarios plus randomized step tables
// checked against a step-level arithmetic model of lean trajectory and step timing.
module tb_segway_stim_seq;

    localparam int DEPTH    = 4;
    localparam int WAIT_W   = 24;
    localparam int SLEW     = 4;
    localparam int SLEW_DIV = 8;
    localparam int ENTRY_W  = 50 + WAIT_W;
`ifdef LEAN_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wr_en;
    logic [1:0]         wr_addr;
    logic [ENTRY_W-1:0] wr_data;
    logic               start;
    logic               abort;
    logic [7:0]         cmd;
    logic               send_cmd;
    logic               cmd_sent;
    logic signed [15:0] rider_lean;
    logic [11:0]        ld_cell_lft;
    logic [11:0]        ld_cell_rght;
    logic [1:0]         step_idx;
    logic               busy;
    logic               done;

    int total = 0;
    int bad   = 0;

    // Reference copy of the step table and the lean the model believes the DUT holds.
    bit       t_last [DEPTH];
    bit       t_has  [DEPTH];
    logic [7:0] t_cmd [DEPTH];
    int       t_lean [DEPTH];
    int       t_ldl  [DEPTH];
    int       t_ldr  [DEPTH];
    int       t_wait [DEPTH];
    int       t_dly  [DEPTH];
    int       m_lean;

    segway_stim_seq #(.DEPTH(DEPTH), .WAIT_W(WAIT_W), .SLEW(SLEW), .SLEW_DIV(SLEW_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .abort(abort), .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
        .rider_lean(rider_lean), .ld_cell_lft(ld_cell_lft), .ld_cell_rght(ld_cell_rght),
        .step_idx(step_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lean(input string tag, input int e);
        logic [15:0] ev;
        logic [15:0] ov;
        ev = e[15:0];
        ov = rider_lean;
        chk(tag, 32'(ov), 32'(ev));
    endtask

    task automatic chk_reset_state();
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_send_cmd", 32'(send_cmd), 0);
        chk_lean("rst_lean", 0);
        chk("rst_ld_lft", 32'(ld_cell_lft), 0);
        chk("rst_ld_rght", 32'(ld_cell_rght), 0);
        chk("rst_step_idx", 32'(step_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
    endtask

    // Lean t cycles into the ramp phase: SLEW per SLEW_DIV cycles, clamped at the target.
    function automatic int exp_lean(input int s, input int tg, input int t);
        int mag, moved;
        mag = (tg > s) ? tg - s : s - tg;
        if (!RAMP_ON) return (t >= 1) ? tg : s;
        moved = (t / SLEW_DIV) * SLEW;
        if (moved > mag) moved = mag;
        return (tg >= s) ? s + moved : s - moved;
    endfunction

    function automatic int ramp_cycles(input int s, input int tg);
        int mag;
        mag = (tg > s) ? tg - s : s - tg;
        if (!RAMP_ON || mag == 0) return 1;
        return ((mag + SLEW - 1) / SLEW) * SLEW_DIV;
    endfunction

    task automatic wr_ent(input int a, input bit last, input bit has, input logic [7:0] c,
                          input int lean, input int ldl, input int ldr, input int w);
        logic [15:0] l16;
        logic [11:0] ll, lr;
        logic [23:0] w24;
        l16 = lean[15:0];
        ll  = ldl[11:0];
        lr  = ldr[11:0];
        w24 = w[23:0];
        t_last[a] = last; t_has[a] = has; t_cmd[a] = c;
        t_lean[a] = lean; t_ldl[a] = ldl; t_ldr[a] = ldr; t_wait[a] = w; t_dly[a] = 1;
        wr_en   = 1'b1;
        wr_addr = a[1:0];
        wr_data = {last, has, c, l16, ll, lr, w24};
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Entered at the negedge after step s's LOAD edge; leaves after the next LOAD edge or after done.
    task automatic run_step(input int s, output bit fin);
        int st, tg, r;
        st = m_lean;
        tg = t_lean[s];
        chk("ld_lft", 32'(ld_cell_lft), 32'(t_ldl[s]));
        chk("ld_rght", 32'(ld_cell_rght), 32'(t_ldr[s]));
        chk("step_idx", 32'(step_idx), 32'(s));
        chk("busy_step", 32'(busy), 1);
        if (t_has[s]) begin
            @(negedge clk);
            chk("send_pulse", 32'(send_cmd), 1);
            chk("cmd_val", 32'(cmd), 32'(t_cmd[s]));
            repeat (t_dly[s] - 1) begin
                @(negedge clk);
                chk("send_low", 32'(send_cmd), 0);
                chk("cmd_stable", 32'(cmd), 32'(t_cmd[s]));
                chk_lean("lean_wait_tx", st);
            end
            cmd_sent = 1'b1;
            @(negedge clk);
            cmd_sent = 1'b0;
            chk("send_low_end", 32'(send_cmd), 0);
            chk_lean("lean_tx_done", st);
        end
        r = ramp_cycles(st, tg);
        for (int t = 1; t <= r; t++) begin
            @(negedge clk);
            chk_lean("lean_ramp", exp_lean(st, tg, t));
        end
        m_lean = tg;
        repeat (t_wait[s]) @(negedge clk);
        chk("done_in_hold", 32'(done), 0);
        chk_lean("lean_hold", tg);
        @(negedge clk);
        fin = t_last[s] || (s == DEPTH - 1);
        if (fin) begin
            chk("done_pulse", 32'(done), 1);
            chk("busy_in_done", 32'(busy), 1);
            @(negedge clk);
            chk("done_clear", 32'(done), 0);
            chk("busy_idle", 32'(busy), 0);
            chk("final_step_idx", 32'(step_idx), 32'(s));
        end else begin
            chk("done_mid", 32'(done), 0);
            @(negedge clk);
        end
    endtask

    task automatic run_seq();
        bit fin;
        chk("busy_before", 32'(busy), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int s = 0; s < DEPTH; s++) begin
            run_step(s, fin);
            if (fin) break;
        end
    endtask

    initial begin
        bit fin;
        int e;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; abort = 1'b0; cmd_sent = 1'b0;
        m_lean = 0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp up to 0x0FFF with 700/700 load cells, hold 100.
        wr_ent(0, 1, 0, 8'h00, 4095, 700, 700, 100);
        run_seq();

        // Reset while the lean is moving.
        wr_ent(0, 1, 0, 8'h00, 0, 5, 6, 300);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        m_lean = 0;
        @(negedge clk);

        // Ramp down from 0 to -4096.
        wr_ent(0, 1, 0, 8'h00, -4096, 1, 2, 3);
        run_seq();

        // Command handshake with a slow tx_done.
        wr_ent(0, 1, 1, 8'h47, -4096 + 40, 100, 200, 5);
        t_dly[0] = 1000;
        run_seq();

        // Abort during step 1, then restart from step 0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_lean = 0;
        wr_ent(0, 0, 0, 8'h00, 0, 10, 20, 0);
        wr_ent(1, 0, 0, 8'h00, 4095, 30, 40, 1000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        run_step(0, fin);
        repeat (400) @(negedge clk);
        e = exp_lean(0, 4095, 400);
        chk_lean("lean_pre_abort", e);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk_lean("abort_lean", e);
        chk("abort_step_idx", 32'(step_idx), 1);
        chk("abort_send", 32'(send_cmd), 0);
        repeat (20) @(negedge clk);
        chk_lean("abort_frozen", e);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_beats_start", 32'(busy), 0);
        @(negedge clk);
        chk("abort_beats_start2", 32'(busy), 0);
        m_lean = e;
        wr_ent(1, 1, 0, 8'h00, 16, 50, 60, 3);
        run_seq();

        // Table end: no last bits, zero hold, one command step.
        wr_ent(0, 0, 0, 8'h00, 12, 111, 222, 0);
        wr_ent(1, 0, 1, 8'hA5, -20, 333, 444, 0);
        t_dly[1] = 3;
        wr_ent(2, 0, 0, 8'h00, 7, 555, 666, 0);
        wr_ent(3, 0, 0, 8'h00, 7, 777, 888, 0);
        run_seq();

        // Randomized tables.
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                wr_ent(a, ($urandom_range(3) == 0), $urandom_range(1), 8'($urandom_range(255)),
                       int'($urandom_range(600)) - 300, $urandom_range(4095), $urandom_range(4095),
                       $urandom_range(15));
                if (t_has[a]) t_dly[a] = $urandom_range(12, 1);
            end
            run_seq();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
